// File: rtl/set_pkg.sv
// Shared definitions for the SET circle-count core and the blocks that share it.
package set_pkg;

  localparam int SET_CENTRAL_W   = 8;
  localparam int SET_RADIUS_W    = 4;
  localparam int SET_CAND_W      = 8;
  localparam int SET_TMO_DEFAULT = 1023;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_VALID,
    RESP
  } set_state_e;

endpackage

// File: rtl/set_rr_arbiter.sv
// Round-robin priority encoder: picks the first set request at or after ptr_i,
// wrapping modulo N, and reports it as a one-hot grant plus its index.
module set_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Offset k is the rotation distance from the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any_o && req_i[j] && (((int'(ptr_i) + k) % N) == j)) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/set_job_arbiter.sv
// Shares one SET core among N_REQ requesters: round-robin job acceptance,
// core en/busy/valid sequencing, tagged responses and a hung-core watchdog.
module set_job_arbiter
  import set_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int TMO   = SET_TMO_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid_i,
  input  logic [SET_CENTRAL_W*N_REQ-1:0]   req_central_i,
  input  logic [SET_RADIUS_W*N_REQ-1:0]    req_radius_i,
  output logic [N_REQ-1:0]                 req_ready_o,
  output logic                             core_en_o,
  output logic [SET_CENTRAL_W-1:0]         core_central_o,
  output logic [SET_RADIUS_W-1:0]          core_radius_o,
  input  logic                             core_busy_i,
  input  logic                             core_valid_i,
  input  logic [SET_CAND_W-1:0]            core_candidate_i,
  output logic                             rsp_valid_o,
  output logic [ID_W-1:0]                  rsp_id_o,
  output logic [SET_CAND_W-1:0]            rsp_data_o,
  output logic                             rsp_err_o,
  input  logic                             rsp_ready_i,
  output logic                             spurious_o
);

  localparam int WD_W = $clog2(TMO + 1);
  localparam logic [WD_W-1:0] TMO_C = WD_W'(TMO);

  set_state_e                state_q, state_d;
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic [N_REQ-1:0]          req_ready_q, req_ready_d;
  logic                      core_en_q, core_en_d;
  logic [SET_CENTRAL_W-1:0]  core_central_q, core_central_d;
  logic [SET_RADIUS_W-1:0]   core_radius_q, core_radius_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic [SET_CAND_W-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      spurious_q, spurious_d;

  logic [N_REQ-1:0]          gnt;
  logic [ID_W-1:0]           gnt_idx;
  logic                      gnt_any;
  logic [WD_W-1:0]           wdog_inc;
  logic                      wdog_hit;

  set_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Saturating so a stuck controller can never wrap back below the limit.
  assign wdog_inc = (wdog_q == TMO_C) ? wdog_q : wdog_q + WD_W'(1);
  assign wdog_hit = (wdog_inc == TMO_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      wdog_q         <= '0;
      req_ready_q    <= '0;
      core_en_q      <= 1'b0;
      core_central_q <= '0;
      core_radius_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      wdog_q         <= wdog_d;
      req_ready_q    <= req_ready_d;
      core_en_q      <= core_en_d;
      core_central_q <= core_central_d;
      core_radius_q  <= core_radius_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      spurious_q     <= spurious_d;
    end
  end

  // req_ready and core_en are set on the IDLE exit edge, so both pulse during ISSUE.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    wdog_d         = wdog_q;
    req_ready_d    = '0;
    core_en_d      = 1'b0;
    core_central_d = core_central_q;
    core_radius_d  = core_radius_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    spurious_d     = spurious_q | (core_valid_i && (state_q != WAIT_VALID));

    case (state_q)
      IDLE: begin
        if (gnt_any && !core_busy_i) begin
          req_ready_d = gnt;
          core_en_d   = 1'b1;
          id_d        = gnt_idx;
          for (int j = 0; j < N_REQ; j++) begin
            if (gnt[j]) begin
              core_central_d = req_central_i[j*SET_CENTRAL_W +: SET_CENTRAL_W];
              core_radius_d  = req_radius_i[j*SET_RADIUS_W +: SET_RADIUS_W];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wdog_d = wdog_inc;
        if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else if (core_busy_i) begin
          state_d = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        wdog_d = wdog_inc;
        // A result arriving on the abort cycle still counts as a real result.
        if (core_valid_i) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = core_candidate_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o    = req_ready_q;
  assign core_en_o      = core_en_q;
  assign core_central_o = core_central_q;
  assign core_radius_o  = core_radius_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign spurious_o     = spurious_q;

endmodule
